// File: rtl/memory_arbiter_if.sv
// Bus bundle for memory_arbiter: instruction/data requester side plus the RAM port.
// The arbiter connects through the slave modport; the requester/RAM environment uses master.
interface memory_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;
  logic              merr;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic [1:0]        ramstate;

  // Handshake: a requester holds xREN/xWEN high until it sees xwait=0 for one cycle;
  // dropping the request earlier aborts the access with no completion.
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, merr, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, merr, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/memory_arbiter.sv
// Shares one RAM port between instruction fetch and data accesses. Data wins by default;
// a streak counter forces an instruction grant after MAX_DSTREAK data completions.
module memory_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 3
) (
  input  logic             CLK,
  input  logic             nRST,
  memory_arbiter_if.slave  bus,
  output logic [1:0]       dbg_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, DSERV = 2'd1, ISERV = 2'd2} state_e;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam logic [3:0] MAX_S     = 4'(MAX_DSTREAK);

  state_e      state_q, state_d;
  logic [3:0]  streak_q, streak_d;

  logic              done, err, dreq;
  logic              iwait_c, dwait_c, merr_c, ren_c, wen_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] store_c, iload_c, dload_c;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    iwait_c  = 1'b1;
    dwait_c  = 1'b1;
    merr_c   = 1'b0;
    ren_c    = 1'b0;
    wen_c    = 1'b0;
    addr_c   = '0;
    store_c  = '0;
    iload_c  = '0;
    dload_c  = '0;
    done     = (bus.ramstate == RS_ACCESS) || (bus.ramstate == RS_ERROR);
    err      = (bus.ramstate == RS_ERROR);
    dreq     = bus.dREN | bus.dWEN;

    case (state_q)
      IDLE: begin
        if (dreq && !(bus.iREN && streak_q >= MAX_S)) state_d = DSERV;
        else if (bus.iREN)                            state_d = ISERV;
      end
      DSERV: begin
        if (!dreq) begin
          state_d = IDLE;
        end else begin
          addr_c  = bus.daddr;
          store_c = bus.dstore;
          wen_c   = bus.dWEN;
          ren_c   = bus.dREN & ~bus.dWEN;
          if (done) begin
            dwait_c = 1'b0;
            dload_c = bus.ramload;
            merr_c  = err;
            state_d = IDLE;
            if (streak_q != 4'hF) streak_d = streak_q + 4'd1;
          end
        end
      end
      ISERV: begin
        if (!bus.iREN) begin
          state_d = IDLE;
        end else begin
          ren_c  = 1'b1;
          addr_c = bus.iaddr;
          if (done) begin
            iwait_c  = 1'b0;
            iload_c  = bus.ramload;
            merr_c   = err;
            state_d  = IDLE;
            streak_d = 4'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The streak only measures how long an instruction request has been waiting.
    if (!bus.iREN) streak_d = 4'd0;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  assign bus.iwait    = iwait_c;
  assign bus.iload    = iload_c;
  assign bus.dwait    = dwait_c;
  assign bus.dload    = dload_c;
  assign bus.merr     = merr_c;
  assign bus.ramREN   = ren_c;
  assign bus.ramWEN   = wen_c;
  assign bus.ramaddr  = addr_c;
  assign bus.ramstore = store_c;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: table vectors, directed corner sequences and
// a randomized run against a transaction-level reference model.
module tb_memory_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 3;
  localparam int VW   = 2 + AW + DW + 1 + DW + 1 + DW + 1;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 2'd3;
  localparam logic [31:0] IA = 32'h40, DA = 32'h100, DS = 32'hDEADBEEF, RL = 32'h8C220004;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic [1:0] dbg_state;

  memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DSTREAK(MAXS)) dut (
    .CLK(CLK), .nRST(nRST), .bus(bus.slave), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  logic [VW-1:0] exp_q[$];
  int m_owner;   // 0 none, 1 data, 2 instruction
  int m_streak;

  function automatic logic [VW-1:0] pack(logic ren, logic wen, logic [AW-1:0] a, logic [DW-1:0] s,
                                         logic iw, logic [DW-1:0] il, logic dw, logic [DW-1:0] dl,
                                         logic m);
    return {ren, wen, a, s, iw, il, dw, dl, m};
  endfunction

  function automatic logic [VW-1:0] idle_out();
    return pack(1'b0, 1'b0, '0, '0, 1'b1, '0, 1'b1, '0, 1'b0);
  endfunction

  function automatic logic [VW-1:0] outs();
    return {bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.iwait, bus.iload,
            bus.dwait, bus.dload, bus.merr};
  endfunction

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic i, input logic d, input logic w, input logic [1:0] rs);
    bus.iREN = i; bus.dREN = d; bus.dWEN = w; bus.ramstate = rs;
  endtask

  task automatic set_bus(input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                         input logic [31:0] rl);
    bus.iaddr = ia; bus.daddr = da; bus.dstore = ds; bus.ramload = rl;
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 1'b0, FREE);
    nRST = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    nRST = 1'b1;
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  // ---------------- reference model ----------------
  task automatic model_cycle(output logic [VW-1:0] e);
    logic dreq, done, is_err;
    logic ren, wen, iw, dw, m;
    logic [AW-1:0] a;
    logic [DW-1:0] s, il, dl;
    int nxt_owner, nxt_streak;
    ren = 0; wen = 0; iw = 1; dw = 1; m = 0; a = '0; s = '0; il = '0; dl = '0;
    dreq   = bus.dREN | bus.dWEN;
    done   = (bus.ramstate == ACC) || (bus.ramstate == ERR);
    is_err = (bus.ramstate == ERR);
    nxt_owner  = m_owner;
    nxt_streak = m_streak;
    if (m_owner == 0) begin
      if (dreq && !(bus.iREN && m_streak >= MAXS)) nxt_owner = 1;
      else if (bus.iREN) nxt_owner = 2;
    end else if (m_owner == 1) begin
      if (!dreq) nxt_owner = 0;
      else begin
        a = bus.daddr; s = bus.dstore; wen = bus.dWEN; ren = bus.dREN && !bus.dWEN;
        if (done) begin
          dw = 0; dl = bus.ramload; m = is_err; nxt_owner = 0;
          nxt_streak = (m_streak < 15) ? m_streak + 1 : 15;
        end
      end
    end else begin
      if (!bus.iREN) nxt_owner = 0;
      else begin
        a = bus.iaddr; ren = 1;
        if (done) begin
          iw = 0; il = bus.ramload; m = is_err; nxt_owner = 0; nxt_streak = 0;
        end
      end
    end
    if (!bus.iREN) nxt_streak = 0;
    e = pack(ren, wen, a, s, iw, il, dw, dl, m);
    m_owner  = nxt_owner;
    m_streak = nxt_streak;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic i, d, w;
    logic [1:0] rs;
    logic ren, wen;
    logic [31:0] addr, store;
    logic iw;
    logic [31:0] il;
    logic dw;
    logic [31:0] dl;
    logic m;
  } vec_t;

  vec_t vecs[9];
  int   exp_order[8] = '{1, 1, 1, 2, 1, 1, 1, 2};
  int   got[$];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic en_prev;
    logic [1:0] rs_prev;
    logic [VW-1:0] e;

    vecs[0] = '{1, 0, 0, BUSY, 1, 0, IA, 0,  1, 0,  1, 0,  0};
    vecs[1] = '{1, 0, 0, ACC,  1, 0, IA, 0,  0, RL, 1, 0,  0};
    vecs[2] = '{1, 0, 0, ERR,  1, 0, IA, 0,  0, RL, 1, 0,  1};
    vecs[3] = '{0, 1, 0, BUSY, 1, 0, DA, DS, 1, 0,  1, 0,  0};
    vecs[4] = '{0, 1, 1, ACC,  0, 1, DA, DS, 1, 0,  0, RL, 0};
    vecs[5] = '{0, 0, 1, ERR,  0, 1, DA, DS, 1, 0,  0, RL, 1};
    vecs[6] = '{1, 1, 0, ACC,  1, 0, DA, DS, 1, 0,  0, RL, 0};
    vecs[7] = '{0, 0, 0, ACC,  0, 0, 0,  0,  1, 0,  1, 0,  0};
    vecs[8] = '{1, 0, 1, FREE, 0, 1, DA, DS, 1, 0,  1, 0,  0};

    set_bus(IA, DA, DS, RL);

    // Reset held with both requests asserted; outputs must stay at reset values.
    set_in(1'b1, 1'b1, 1'b0, BUSY);
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_outputs", outs(), idle_out());
    step(); nRST = 1'b1;
    step();
    @(negedge CLK);
    check("first_grant_data", outs(), pack(1, 0, DA, DS, 1, 0, 1, 0, 0));

    // Instruction read with two BUSY cycles, then ACCESS, then the IDLE bubble.
    set_in(1'b0, 1'b0, 1'b0, BUSY);
    step();
    set_in(1'b1, 1'b0, 1'b0, BUSY);
    step(); @(negedge CLK);
    check("ifetch_busy1", outs(), pack(1, 0, IA, 0, 1, 0, 1, 0, 0));
    step(); @(negedge CLK);
    check("ifetch_busy2", outs(), pack(1, 0, IA, 0, 1, 0, 1, 0, 0));
    step(); bus.ramstate = ACC; @(negedge CLK);
    check("ifetch_done", outs(), pack(1, 0, IA, 0, 0, RL, 1, 0, 0));
    step(); bus.ramstate = BUSY; @(negedge CLK);
    check("ifetch_bubble", outs(), idle_out());

    // Table vectors: enter the granted state from reset, then apply one ramstate.
    for (int k = 0; k < 9; k++) begin
      do_reset();
      set_in(vecs[k].i, vecs[k].d, vecs[k].w, BUSY);
      step();
      bus.ramstate = vecs[k].rs;
      @(negedge CLK);
      check($sformatf("vec_%0d", k), outs(),
            pack(vecs[k].ren, vecs[k].wen, vecs[k].addr, vecs[k].store, vecs[k].iw, vecs[k].il,
                 vecs[k].dw, vecs[k].dl, vecs[k].m));
    end

    // Store completes, then bubble.
    do_reset();
    set_in(1'b0, 1'b1, 1'b1, BUSY);
    step(); @(negedge CLK);
    check("store_drive", outs(), pack(0, 1, DA, DS, 1, 0, 1, 0, 0));
    step(); bus.ramstate = ACC; @(negedge CLK);
    check("store_done", outs(), pack(0, 1, DA, DS, 1, 0, 0, RL, 0));
    step(); bus.ramstate = BUSY; @(negedge CLK);
    check("store_bubble", outs(), idle_out());

    // Both requests held; RAM answers ACCESS on the second enabled cycle.
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, BUSY);
    en_prev = 1'b0; rs_prev = BUSY; got.delete();
    for (int c = 0; c < 100 && got.size() < 8; c++) begin
      step();
      bus.ramstate = (en_prev && rs_prev == BUSY) ? ACC : BUSY;
      @(negedge CLK);
      if (!bus.dwait) got.push_back(1);
      else if (!bus.iwait) got.push_back(2);
      en_prev = bus.ramREN | bus.ramWEN;
      rs_prev = bus.ramstate;
    end
    check("grant_count", VW'(got.size()), VW'(8));
    for (int k = 0; k < got.size() && k < 8; k++)
      check($sformatf("grant_order_%0d", k), VW'(got[k]), VW'(exp_order[k]));

    // Abort after two data completions; the streak must stay at 2.
    do_reset();
    set_in(1'b1, 1'b1, 1'b0, BUSY);
    step();
    step(); bus.ramstate = ACC;
    step(); bus.ramstate = BUSY;
    step(); bus.ramstate = ACC;
    step(); bus.ramstate = BUSY;
    step(); #1;
    check("abort_pre", outs(), pack(1, 0, DA, DS, 1, 0, 1, 0, 0));
    bus.dREN = 1'b0; #1;
    check("abort_drop", outs(), idle_out());
    step(); bus.dREN = 1'b1; @(negedge CLK);
    check("abort_idle", outs(), idle_out());
    step(); bus.ramstate = ACC; @(negedge CLK);
    check("abort_streak_kept", outs(), pack(1, 0, DA, DS, 1, 0, 0, RL, 0));
    step(); bus.ramstate = BUSY;
    step(); @(negedge CLK);
    check("abort_then_ifetch", outs(), pack(1, 0, IA, 0, 1, 0, 1, 0, 0));

    // ERROR on an instruction access, then ERROR while idle.
    do_reset();
    set_in(1'b1, 1'b0, 1'b0, BUSY);
    step();
    step(); bus.ramstate = ERR; @(negedge CLK);
    check("ierr_done", outs(), pack(1, 0, IA, 0, 0, RL, 1, 0, 1));
    step(); bus.iREN = 1'b0; @(negedge CLK);
    check("err_idle_a", outs(), idle_out());
    step(); @(negedge CLK);
    check("err_idle_b", outs(), idle_out());

    // Asynchronous reset in the middle of a data access.
    do_reset();
    set_in(1'b0, 1'b1, 1'b0, BUSY);
    step(); #1;
    nRST = 1'b0; #1;
    check("async_reset", outs(), idle_out());
    step(); nRST = 1'b1;

    // Randomized run against the model.
    do_reset();
    m_owner = 0; m_streak = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] rs;
      step();
      if ($urandom_range(0, 5) == 0) bus.iREN = ~bus.iREN;
      if ($urandom_range(0, 5) == 0) bus.dREN = ~bus.dREN;
      if ($urandom_range(0, 7) == 0) bus.dWEN = ~bus.dWEN;
      set_bus($urandom, $urandom, $urandom, $urandom);
      rs = 2'($urandom_range(0, 3));
      if ((m_owner == 1 && !(bus.dREN | bus.dWEN)) || (m_owner == 2 && !bus.iREN))
        rs = 2'($urandom_range(0, 1));
      bus.ramstate = rs;
      @(negedge CLK);
      model_cycle(e);
      exp_q.push_back(e);
      check($sformatf("rand_%0d", c), outs(), exp_q.pop_front());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
